piso_serializer: RTL and testbench

//   Parallel-in, serial-out transmitter. It is the sending end of the team's

---
 rtl/piso_serializer.sv | 116 +++++++++++
 tb/tb_piso_serializer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// piso_serializer : parallel-in serial-out transmitter with gapless reload
// rev 1.0
// ----------------------------------------------------------------------------
module piso_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] d,
  output logic             q,
  output logic             q_valid,
  output logic             last
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] C_CNT_RELOAD = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             q_q, q_d;
  logic             q_valid_q, q_valid_d;

  logic             accept;
  logic             first_bit;
  logic [WIDTH-1:0] sr_shifted;
  logic             next_bit;

  // The bit on q always mirrors the "head" end of sr, so after a shift the
  // next bit to send sits at the same end of the shifted register.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign first_bit  = d[WIDTH-1];
      assign sr_shifted = sr_q << 1;
      assign next_bit   = sr_shifted[WIDTH-1];
    end else begin : g_lsb_first
      assign first_bit  = d[0];
      assign sr_shifted = sr_q >> 1;
      assign next_bit   = sr_shifted[0];
    end
  endgenerate

  assign last       = q_valid_q & (cnt_q == '0);
  assign load_ready = (state_q == IDLE) | last;
  assign accept     = load_valid & load_ready;
  assign q          = q_q;
  assign q_valid    = q_valid_q;

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    q_d       = q_q;
    q_valid_d = q_valid_q;

    if (accept) begin
      sr_d      = d;
      q_d       = first_bit;
      q_valid_d = 1'b1;
      cnt_d     = C_CNT_RELOAD;
      state_d   = SHIFT;
    end else begin
      case (state_q)
        IDLE: begin
          q_d       = IDLE_LEVEL;
          q_valid_d = 1'b0;
        end
        SHIFT: begin
          if (cnt_q != '0) begin
            sr_d  = sr_shifted;
            q_d   = next_bit;
            cnt_d = cnt_q - 1'b1;
          end else begin
            state_d   = IDLE;
            q_d       = IDLE_LEVEL;
            q_valid_d = 1'b0;
          end
        end
        default: begin
          state_d   = IDLE;
          q_d       = IDLE_LEVEL;
          q_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      cnt_q     <= '0;
      q_q       <= IDLE_LEVEL;
      q_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_piso_serializer : bench for piso_serializer, MSB-first and LSB-first
// rev 1.0
// ----------------------------------------------------------------------------
module tb_piso_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         lv_m = 1'b0, lv_l = 1'b0;
  logic [W-1:0] d_m = '0, d_l = '0;
  logic         rdy_m, q_m, qv_m, last_m;
  logic         rdy_l, q_l, qv_l, last_l;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_m (
    .clk(clk), .rst_n(rst_n), .load_valid(lv_m), .load_ready(rdy_m),
    .d(d_m), .q(q_m), .q_valid(qv_m), .last(last_m)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .load_valid(lv_l), .load_ready(rdy_l),
    .d(d_l), .q(q_l), .q_valid(qv_l), .last(last_l)
  );

  int checks = 0;
  int errors = 0;
  bit sel = 1'b0;  // 0: MSB-first DUT active, 1: LSB-first DUT active

  logic o_q, o_qv, o_last, o_rdy;
  assign o_q    = sel ? q_l    : q_m;
  assign o_qv   = sel ? qv_l   : qv_m;
  assign o_last = sel ? last_l : last_m;
  assign o_rdy  = sel ? rdy_l  : rdy_m;

  // Reference: a queue of the bits still owed on q, each tagged with "last".
  bit exp_b[$];
  bit exp_l[$];
  logic eq, ev, el, er;

  function automatic bit bit_of(input logic [W-1:0] w, input int i, input bit msb);
    return msb ? w[W-1-i] : w[i];
  endfunction

  task automatic model_clear();
    exp_b.delete();
    exp_l.delete();
  endtask

  task automatic model_expect();
    if (exp_b.size() == 0) begin
      eq = 1'b0; ev = 1'b0; el = 1'b0; er = 1'b1;
    end else begin
      eq = exp_b[0]; ev = 1'b1; el = exp_l[0]; er = exp_l[0];
    end
  endtask

  task automatic model_edge(input bit acc, input logic [W-1:0] w);
    if (exp_b.size() != 0) begin
      void'(exp_b.pop_front());
      void'(exp_l.pop_front());
    end
    if (acc) begin
      for (int i = 0; i < W; i++) begin
        exp_b.push_back(bit_of(w, i, !sel));
        exp_l.push_back(i == W - 1);
      end
    end
  endtask

  task automatic drive(input bit lv, input logic [W-1:0] dv);
    lv_m = sel ? 1'b0 : lv;
    d_m  = sel ? '0   : dv;
    lv_l = sel ? lv   : 1'b0;
    d_l  = sel ? dv   : '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    lv_m = 1'b1; lv_l = 1'b1; d_m = 8'hFF; d_l = 8'hFF;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks += 8;
      if (q_m !== 1'b0)    begin errors++; $display("FAIL reset q_m k%0d got %b exp 0", k, q_m); end
      if (qv_m !== 1'b0)   begin errors++; $display("FAIL reset qv_m k%0d got %b exp 0", k, qv_m); end
      if (last_m !== 1'b0) begin errors++; $display("FAIL reset last_m k%0d got %b exp 0", k, last_m); end
      if (rdy_m !== 1'b1)  begin errors++; $display("FAIL reset rdy_m k%0d got %b exp 1", k, rdy_m); end
      if (q_l !== 1'b0)    begin errors++; $display("FAIL reset q_l k%0d got %b exp 0", k, q_l); end
      if (qv_l !== 1'b0)   begin errors++; $display("FAIL reset qv_l k%0d got %b exp 0", k, qv_l); end
      if (last_l !== 1'b0) begin errors++; $display("FAIL reset last_l k%0d got %b exp 0", k, last_l); end
      if (rdy_l !== 1'b1)  begin errors++; $display("FAIL reset rdy_l k%0d got %b exp 1", k, rdy_l); end
      tick();
    end
    lv_m = 1'b0; lv_l = 1'b0;
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_single();
    sel = 1'b0;
    for (int c = 0; c < 11; c++) begin
      drive(c == 0, 8'hA5);
      model_expect();
      checks += 4;
      if (o_q !== eq)     begin errors++; $display("FAIL single q c%0d got %b exp %b", c, o_q, eq); end
      if (o_qv !== ev)    begin errors++; $display("FAIL single q_valid c%0d got %b exp %b", c, o_qv, ev); end
      if (o_last !== el)  begin errors++; $display("FAIL single last c%0d got %b exp %b", c, o_last, el); end
      if (o_rdy !== er)   begin errors++; $display("FAIL single load_ready c%0d got %b exp %b", c, o_rdy, er); end
      model_edge((c == 0) && er, 8'hA5);
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w;
    sel = 1'b0;
    for (int c = 0; c < 20; c++) begin
      w = (c == 0) ? 8'hA5 : 8'h3C;
      drive(c <= 8, w);
      model_expect();
      checks += 4;
      if (o_q !== eq)     begin errors++; $display("FAIL b2b q c%0d got %b exp %b", c, o_q, eq); end
      if (o_qv !== ev)    begin errors++; $display("FAIL b2b q_valid c%0d got %b exp %b", c, o_qv, ev); end
      if (o_last !== el)  begin errors++; $display("FAIL b2b last c%0d got %b exp %b", c, o_last, el); end
      if (o_rdy !== er)   begin errors++; $display("FAIL b2b load_ready c%0d got %b exp %b", c, o_rdy, er); end
      model_edge((c <= 8) && er, w);
      tick();
    end
  endtask

  task automatic test_lsb_first();
    logic [W-1:0] w;
    sel = 1'b1;
    for (int c = 0; c < 11; c++) begin
      w = (c == 0) ? 8'h01 : 8'hFF;
      drive(c == 0, w);
      model_expect();
      checks += 4;
      if (o_q !== eq)     begin errors++; $display("FAIL lsb q c%0d got %b exp %b", c, o_q, eq); end
      if (o_qv !== ev)    begin errors++; $display("FAIL lsb q_valid c%0d got %b exp %b", c, o_qv, ev); end
      if (o_last !== el)  begin errors++; $display("FAIL lsb last c%0d got %b exp %b", c, o_last, el); end
      if (o_rdy !== er)   begin errors++; $display("FAIL lsb load_ready c%0d got %b exp %b", c, o_rdy, er); end
      model_edge((c == 0) && er, w);
      tick();
    end
  endtask

  task automatic test_busy();
    logic [W-1:0] w1, w2, w;
    bit lv;
    w1 = W'($urandom);
    w2 = W'($urandom);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int c = 0; c < 20; c++) begin
        lv = (c == 0) || (c >= 3 && c <= 8);
        w  = (c == 0) ? w1 : w2;
        drive(lv, w);
        model_expect();
        checks += 4;
        if (o_q !== eq)     begin errors++; $display("FAIL busy q s%0d c%0d got %b exp %b", s, c, o_q, eq); end
        if (o_qv !== ev)    begin errors++; $display("FAIL busy q_valid s%0d c%0d got %b exp %b", s, c, o_qv, ev); end
        if (o_last !== el)  begin errors++; $display("FAIL busy last s%0d c%0d got %b exp %b", s, c, o_last, el); end
        if (o_rdy !== er)   begin errors++; $display("FAIL busy load_ready s%0d c%0d got %b exp %b", s, c, o_rdy, er); end
        model_edge(lv && er, w);
        tick();
      end
    end
  endtask

  task automatic test_reset_mid_word();
    sel = 1'b0;
    for (int c = 0; c < 5; c++) begin
      drive(c == 0, 8'hFF);
      model_expect();
      checks += 2;
      if (o_q !== eq)   begin errors++; $display("FAIL midrst pre q c%0d got %b exp %b", c, o_q, eq); end
      if (o_qv !== ev)  begin errors++; $display("FAIL midrst pre q_valid c%0d got %b exp %b", c, o_qv, ev); end
      if (c < 4) begin
        model_edge((c == 0) && er, 8'hFF);
        tick();
      end
    end
    #1 rst_n = 1'b0;
    #1;
    model_clear();
    checks += 4;
    if (q_m !== 1'b0)    begin errors++; $display("FAIL midrst q got %b exp 0", q_m); end
    if (qv_m !== 1'b0)   begin errors++; $display("FAIL midrst q_valid got %b exp 0", qv_m); end
    if (last_m !== 1'b0) begin errors++; $display("FAIL midrst last got %b exp 0", last_m); end
    if (rdy_m !== 1'b1)  begin errors++; $display("FAIL midrst load_ready got %b exp 1", rdy_m); end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 11; c++) begin
      drive(c == 0, 8'h80);
      model_expect();
      checks += 4;
      if (o_q !== eq)     begin errors++; $display("FAIL midrst post q c%0d got %b exp %b", c, o_q, eq); end
      if (o_qv !== ev)    begin errors++; $display("FAIL midrst post q_valid c%0d got %b exp %b", c, o_qv, ev); end
      if (o_last !== el)  begin errors++; $display("FAIL midrst post last c%0d got %b exp %b", c, o_last, el); end
      if (o_rdy !== er)   begin errors++; $display("FAIL midrst post load_ready c%0d got %b exp %b", c, o_rdy, er); end
      model_edge((c == 0) && er, 8'h80);
      tick();
    end
  endtask

  task automatic test_random();
    logic [W-1:0] w;
    bit lv;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int c = 0; c < 260; c++) begin
        lv = (c < 250) && ($urandom_range(0, 3) != 0);
        w  = W'($urandom);
        drive(lv, w);
        model_expect();
        checks += 4;
        if (o_q !== eq)     begin errors++; $display("FAIL rand q s%0d c%0d got %b exp %b", s, c, o_q, eq); end
        if (o_qv !== ev)    begin errors++; $display("FAIL rand q_valid s%0d c%0d got %b exp %b", s, c, o_qv, ev); end
        if (o_last !== el)  begin errors++; $display("FAIL rand last s%0d c%0d got %b exp %b", s, c, o_last, el); end
        if (o_rdy !== er)   begin errors++; $display("FAIL rand load_ready s%0d c%0d got %b exp %b", s, c, o_rdy, er); end
        model_edge(lv && er, w);
        tick();
      end
    end
  endtask

  initial begin
    test_reset();
    tick();
    test_single();
    test_back_to_back();
    test_lsb_first();
    test_busy();
    test_reset_mid_word();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
